// File: rtl/modport_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : modport_gray_counter
//  Brief    : Free-running Gray-code counter with synchronous active-high
//             reset. The optional MODPORT_GRAY_CNT_CHECK_EN build adds a
//             sticky single-bit-transition self-check flag (gray_err).
//  Revision : 1.0  initial release
// ============================================================================
module modport_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] gray_count
`ifdef MODPORT_GRAY_CNT_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    logic [WIDTH-1:0] r_bin_q;
    logic [WIDTH-1:0] r_gray_q;
    logic [WIDTH-1:0] w_next_gray;

    assign w_next_gray = r_bin_q ^ (r_bin_q >> 1);

    // Binary counter runs one step ahead so the Gray output is purely registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin_q  <= WIDTH'(1);
            r_gray_q <= '0;
        end else begin
            r_gray_q <= w_next_gray;
            r_bin_q  <= r_bin_q + WIDTH'(1);
        end
    end

    assign gray_count = r_gray_q;

`ifdef MODPORT_GRAY_CNT_CHECK_EN
    logic [WIDTH-1:0] w_step_diff;
    logic             w_step_bad;
    logic             r_gray_err;

    // r_gray_q is the previous value relative to w_next_gray; a legal step
    // has exactly one bit set in the difference (non-zero power of two).
    assign w_step_diff = r_gray_q ^ w_next_gray;
    assign w_step_bad  = (w_step_diff == '0) ||
                         ((w_step_diff & (w_step_diff - WIDTH'(1))) != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gray_err <= 1'b0;
        end else if (w_step_bad) begin
            r_gray_err <= 1'b1;
        end
    end

    assign gray_err = r_gray_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modport_gray_counter.sv
`default_nettype none
// Self-checking bench: three counter widths against an edge-count Gray model.
module tb_modport_gray_counter;

    logic       clock;
    logic       reset;
    logic [2:0] g3;
    logic [3:0] g4;
    logic [7:0] g8;
`ifdef MODPORT_GRAY_CNT_CHECK_EN
    logic       e3, e4, e8;
`endif

    modport_gray_counter #(.WIDTH(3)) u3 (
        .clock(clock), .reset(reset), .gray_count(g3)
`ifdef MODPORT_GRAY_CNT_CHECK_EN
        , .gray_err(e3)
`endif
    );
    modport_gray_counter #(.WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .gray_count(g4)
`ifdef MODPORT_GRAY_CNT_CHECK_EN
        , .gray_err(e4)
`endif
    );
    modport_gray_counter #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .gray_count(g8)
`ifdef MODPORT_GRAY_CNT_CHECK_EN
        , .gray_err(e8)
`endif
    );

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: number of non-reset edges since the last reset edge.
    int unsigned m_cnt   = 0;
    logic        m_valid = 1'b0;
    logic        suspend = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else begin
            m_cnt   <= m_cnt + 1;
        end
    end

    function automatic logic [15:0] gray_of(input int unsigned n, input int w);
        int unsigned m;
        m = n % (32'd1 << w);
        return 16'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [2:0] p3;
    logic [3:0] p4;
    logic [7:0] p8;

    always @(negedge clock) begin
        if (m_valid && !suspend) begin
            chk("model_w3", 16'(g3), gray_of(m_cnt, 3));
            chk("model_w4", 16'(g4), gray_of(m_cnt, 4));
            chk("model_w8", 16'(g8), gray_of(m_cnt, 8));
            if (m_cnt > 0) begin
                chk("onebit_w3", 16'($countones(p3 ^ g3)), 16'd1);
                chk("onebit_w4", 16'($countones(p4 ^ g4)), 16'd1);
                chk("onebit_w8", 16'($countones(p8 ^ g8)), 16'd1);
            end
`ifdef MODPORT_GRAY_CNT_CHECK_EN
            chk("err_quiet", {13'd0, e3, e4, e8}, 16'd0);
`endif
        end
        p3 = g3;
        p4 = g4;
        p8 = g8;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [3:0] seq4 [16];
    logic [2:0] seq3 [8];
    logic [3:0] fv4;
    bit         found;

    initial begin
        seq4 = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        seq3 = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
        reset = 1'b1;

        repeat (3) begin
            @(negedge clock);
            chk("reset_hold", 16'(g4), 16'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            chk("seq_w4", 16'(g4), 16'(seq4[i % 16]));
            if (i < 8) chk("seq_w3", 16'(g3), 16'(seq3[i]));
            if (i == 8) chk("wrap_w3", 16'(g3), 16'h1);
        end

        // Mid-run reset once the count reaches 7
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (g4 == 4'h7) found = 1'b1;
        end
        chk("reach_7", 16'(found), 16'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_zero", 16'(g4), 16'h0);
        reset = 1'b0;
        @(negedge clock); chk("midrst_1", 16'(g4), 16'h1);
        @(negedge clock); chk("midrst_3", 16'(g4), 16'h3);
        @(negedge clock); chk("midrst_2", 16'(g4), 16'h2);

        // WIDTH=8 tail of the period: edge 254 -> 0x81, 255 -> 0x80, 256 -> 0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (253) @(negedge clock);
        @(negedge clock); chk("w8_edge254", 16'(g8), 16'h81);
        @(negedge clock); chk("w8_edge255", 16'(g8), 16'h80);
        @(negedge clock); chk("w8_edge256", 16'(g8), 16'h00);
        @(negedge clock); chk("w8_edge257", 16'(g8), 16'h01);

        // Randomised reset pulses over long free-running stretches
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 39) == 0);
        end
        reset = 1'b0;
        repeat (300) @(negedge clock);

`ifdef MODPORT_GRAY_CNT_CHECK_EN
        // Repeat the current binary state so the next step changes no bit
        @(negedge clock);
        suspend = 1'b1;
        fv4 = 4'(m_cnt % 16);
        force u4.r_bin_q = fv4;
        @(posedge clock);
        #1;
        release u4.r_bin_q;
        @(negedge clock);
        chk("err_set", 16'(e4), 16'd1);
        repeat (3) begin
            @(negedge clock);
            chk("err_sticky", 16'(e4), 16'd1);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("err_cleared", 16'(e4), 16'd0);
        chk("err_rst_count", 16'(g4), 16'h0);
        reset = 1'b0;
        suspend = 1'b0;
        repeat (20) @(negedge clock);
`else
        fv4 = 4'h0;
        found = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
